// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types, constants and address-range helper for the
//            data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

    // 33-bit compare so a window ending at the top of the address space
    // does not wrap to zero.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [32:0] w_a;
        logic [32:0] w_lo;
        logic [32:0] w_hi;
        w_a  = {1'b0, addr};
        w_lo = {1'b0, base};
        w_hi = w_lo + 33'(depth) * 33'(WORD_BYTES);
        return (w_a >= w_lo) && (w_a < w_hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module   : dmem_array
// Brief    : DEPTH_WORDS x 32 storage, synchronous per-lane write and
//            registered read with a clear-to-zero option.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_wr_en,
    input  logic [3:0]       i_wr_be,
    input  logic [31:0]      i_wr_data,
    input  logic             i_rd_en,
    input  logic             i_rd_clr,
    output logic [31:0]      o_rd_data
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rd_data;

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wr_be[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_clr ? 32'd0 : r_mem[i_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding load/store responder with fixed wait states,
//            one-cycle ready pulse and misalign/range error flag.
// Options  : DMEM_BYTE_EN_EN adds mem_be[3:0] byte-lane store enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [3:0]  mem_be,
`endif
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_busy
);

    localparam int unsigned c_idx_w    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_cnt_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic                 r_we;
    logic                 r_err;
    logic [c_idx_w-1:0]   r_idx;
    logic [31:0]          r_wdata;
    logic [3:0]           r_be;

    logic                 w_accept;
    logic [31:0]          w_in_off;
    logic [c_idx_w-1:0]   w_in_idx;
    logic                 w_in_err;
    logic [3:0]           w_in_be;
    logic                 w_cur_we;
    logic                 w_cur_err;
    logic [c_idx_w-1:0]   w_cur_idx;
    logic [31:0]          w_cur_wdata;
    logic [3:0]           w_cur_be;
    logic                 w_enter_resp;
    logic                 w_unused;

`ifdef DMEM_BYTE_EN_EN
    assign w_in_be = mem_be;
`else
    assign w_in_be = 4'hF;
`endif

    assign w_accept = (r_state == IDLE) && mem_req;
    assign w_in_off = mem_addr - BASE_ADDR;
    assign w_in_idx = w_in_off[c_idx_w+1:2];
    assign w_in_err = (mem_addr[1:0] != 2'b00) ||
                      !addr_in_range(mem_addr, BASE_ADDR, DEPTH_WORDS);
    assign w_unused = &{1'b0, w_in_off[31:c_idx_w+2], w_in_off[1:0]};

    // With zero wait states RESP is entered on the accepting edge itself,
    // so the incoming request feeds the array directly instead of the latch.
    assign w_cur_we    = (r_state == IDLE) ? mem_we    : r_we;
    assign w_cur_err   = (r_state == IDLE) ? w_in_err  : r_err;
    assign w_cur_idx   = (r_state == IDLE) ? w_in_idx  : r_idx;
    assign w_cur_wdata = (r_state == IDLE) ? mem_wdata : r_wdata;
    assign w_cur_be    = (r_state == IDLE) ? w_in_be   : r_be;

    assign w_enter_resp = (w_next == RESP) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept && (WAIT_CYCLES != 0)) begin
            r_cnt <= c_cnt_load;
        end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_we    <= mem_we;
            r_err   <= w_in_err;
            r_idx   <= w_in_idx;
            r_wdata <= mem_wdata;
            r_be    <= w_in_be;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_idx_w)
    ) u_array (
        .clk       (clk),
        .rst       (reset),
        .i_idx     (w_cur_idx),
        .i_wr_en   (w_enter_resp && w_cur_we && !w_cur_err),
        .i_wr_be   (w_cur_be),
        .i_wr_data (w_cur_wdata),
        .i_rd_en   (w_enter_resp),
        .i_rd_clr  (w_cur_we || w_cur_err),
        .o_rd_data (mem_rdata)
    );

    assign mem_ready = (r_state == RESP);
    assign mem_err   = (r_state == RESP) && r_err;
    assign mem_busy  = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Randomized self-checking bench: two responders (2 and 0 wait
//            states) compared against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, a_err, a_busy, b_ready, b_err, b_busy;
`ifdef DMEM_BYTE_EN_EN
    logic [3:0]  a_be, b_be;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_a [64];
    logic [31:0] ref_b [16];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (a_req),
        .mem_we    (a_we),
        .mem_addr  (a_addr),
        .mem_wdata (a_wdata),
`ifdef DMEM_BYTE_EN_EN
        .mem_be    (a_be),
`endif
        .mem_rdata (a_rdata),
        .mem_ready (a_ready),
        .mem_err   (a_err),
        .mem_busy  (a_busy)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (b_req),
        .mem_we    (b_we),
        .mem_addr  (b_addr),
        .mem_wdata (b_wdata),
`ifdef DMEM_BYTE_EN_EN
        .mem_be    (b_be),
`endif
        .mem_rdata (b_rdata),
        .mem_ready (b_ready),
        .mem_err   (b_err),
        .mem_busy  (b_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] addr, input longint base, input longint depth);
        longint a;
        a = longint'(addr);
        return (addr[1:0] != 2'b00) || (a < base) || (a >= base + depth * 4);
    endfunction

    // One transaction on DUT A (2 wait states, 64 words, base 0).
    task automatic run_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        int          lat;
        int          idx;
        logic        e_err;
        logic [31:0] e_rd;
        logic [3:0]  eff_be;
        logic [31:0] rd;
`ifdef DMEM_BYTE_EN_EN
        eff_be = be;
`else
        eff_be = 4'hF;
`endif
        e_err = ref_err(addr, 0, 64);
        idx   = e_err ? 0 : int'(longint'(addr) / 4);
        e_rd  = (!e_err && !we) ? ref_a[idx] : 32'd0;

        @(negedge clk);
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
`ifdef DMEM_BYTE_EN_EN
        a_be = be;
`endif
        @(posedge clk); #1;
        a_req = 1'b0;
        check_val("a_busy_after_accept", 32'(a_busy), 32'd1);
        lat = 1;
        while (!a_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("a_latency", 32'(lat), 32'd3);
        check_val("a_err", 32'(a_err), 32'(e_err));
        check_val("a_rdata", a_rdata, e_rd);
        check_val("a_busy_in_resp", 32'(a_busy), 32'd1);
        rd = a_rdata;
        @(posedge clk); #1;
        check_val("a_ready_pulse_end", 32'(a_ready), 32'd0);
        check_val("a_err_cleared", 32'(a_err), 32'd0);
        check_val("a_busy_idle", 32'(a_busy), 32'd0);
        check_val("a_rdata_hold", a_rdata, rd);

        if (!e_err && we) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_be[i]) ref_a[idx][8*i +: 8] = wdata[8*i +: 8];
            end
        end
    endtask

    // DUT B: mem_req held high. Even cycles carry real requests, odd cycles
    // (the RESP cycle) carry a poison store that must never be accepted.
    task automatic run_b_burst();
        logic        t_we    [7];
        logic [31:0] t_addr  [7];
        logic [31:0] t_wdata [7];
        logic        e_err;
        logic [31:0] e_rd;
        int          idx;
        t_we[0] = 1'b1; t_addr[0] = 32'h1000; t_wdata[0] = 32'h0000_1111;
        t_we[1] = 1'b0; t_addr[1] = 32'h1000; t_wdata[1] = 32'h0;
        t_we[2] = 1'b1; t_addr[2] = 32'h1004; t_wdata[2] = 32'h0000_2222;
        t_we[3] = 1'b0; t_addr[3] = 32'h1004; t_wdata[3] = 32'h0;
        t_we[4] = 1'b0; t_addr[4] = 32'h0FFC; t_wdata[4] = 32'h0;
        t_we[5] = 1'b0; t_addr[5] = 32'h1040; t_wdata[5] = 32'h0;
        t_we[6] = 1'b0; t_addr[6] = 32'h1000; t_wdata[6] = 32'h0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            b_req = 1'b1;
`ifdef DMEM_BYTE_EN_EN
            b_be = 4'hF;
`endif
            if (k % 2 == 0) begin
                b_we = t_we[k/2]; b_addr = t_addr[k/2]; b_wdata = t_wdata[k/2];
            end else begin
                b_we = 1'b1; b_addr = 32'h1000; b_wdata = 32'hBAD0_BAD0;
            end
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                e_err = ref_err(t_addr[k/2], 32'h1000, 16);
                idx   = e_err ? 0 : int'((longint'(t_addr[k/2]) - 32'h1000) / 4);
                e_rd  = (!e_err && !t_we[k/2]) ? ref_b[idx] : 32'd0;
                if (!e_err && t_we[k/2]) ref_b[idx] = t_wdata[k/2];
                check_val("b_ready_accept", 32'(b_ready), 32'd1);
                check_val("b_err", 32'(b_err), 32'(e_err));
                check_val("b_rdata", b_rdata, e_rd);
                check_val("b_busy_resp", 32'(b_busy), 32'd1);
            end else begin
                check_val("b_ready_gap", 32'(b_ready), 32'd0);
                check_val("b_busy_gap", 32'(b_busy), 32'd0);
            end
        end
        @(negedge clk);
        b_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_a_ready"}, 32'(a_ready), 32'd0);
        check_val({tag, "_a_err"},   32'(a_err),   32'd0);
        check_val({tag, "_a_rdata"}, a_rdata,      32'd0);
        check_val({tag, "_a_busy"},  32'(a_busy),  32'd0);
        check_val({tag, "_b_ready"}, 32'(b_ready), 32'd0);
        check_val({tag, "_b_err"},   32'(b_err),   32'd0);
        check_val({tag, "_b_rdata"}, b_rdata,      32'd0);
        check_val({tag, "_b_busy"},  32'(b_busy),  32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        int          kind;
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
`ifdef DMEM_BYTE_EN_EN
        a_be = 4'hF; b_be = 4'hF;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) run_a(1'b1, 32'(i * 4), $urandom, 4'hF);

        run_a(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        run_a(1'b0, 32'h10, 32'h0, 4'hF);
        run_a(1'b0, 32'h13, 32'h0, 4'hF);
        run_a(1'b1, 32'h22, 32'hCAFE_F00D, 4'hF);
        run_a(1'b0, 32'h20, 32'h0, 4'hF);
        run_a(1'b1, 32'h100, 32'h5555_AAAA, 4'hF);
        run_a(1'b1, 32'hFC, 32'hA5A5_0FF0, 4'hF);
        run_a(1'b0, 32'hFC, 32'h0, 4'hF);
        run_a(1'b0, 32'h100, 32'h0, 4'hF);
        run_a(1'b1, 32'hFFFF_FFFC, 32'h1, 4'hF);

        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (kind == 1) addr = 32'h100 + 32'($urandom_range(0, 1000) * 4);
            else if (kind == 2) addr = 32'hFFFF_FF00 + 32'($urandom_range(0, 63) * 4);
            else                addr = 32'($urandom_range(0, 63) * 4);
            run_a(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
        end

`ifdef DMEM_BYTE_EN_EN
        run_a(1'b1, 32'h4, 32'h1122_3344, 4'hF);
        run_a(1'b1, 32'h4, 32'h0000_AA00, 4'b0010);
        run_a(1'b0, 32'h4, 32'h0, 4'hF);
        check_val("be_merge_rdata", a_rdata, 32'h1122_AA44);
        run_a(1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000);
        run_a(1'b0, 32'h4, 32'h0, 4'hF);
        check_val("be_zero_rdata", a_rdata, 32'h1122_AA44);
`endif

        // Reset while the store sits in WAIT: dropped, no ready, no write.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h8; a_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset_in_wait");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_val("no_ready_after_drop", 32'(a_ready), 32'd0);
        end
        run_a(1'b0, 32'h8, 32'h0, 4'hF);

        run_b_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule

`default_nettype wire
